ex_stage_md: RTL and testbench
==============================

// Module: ex_stage_md
// PURPOSE
//  Parametrised execute stage: MEM>WB operand forwarding, integrated ALU, iterative
//  HI/LO multiply/divide unit with stall handshake, EX/MEM pipeline register with flush.
//  Sits between ID/EX and MEM; ex_result/ex_write_register feed ID-stage forwarding.
// PARAMETERS
//  XLEN      32   datapath width (>=8, even)
//  RAW       5    register-index width
//  LINK_REG  31   destination for ex_reg_dst=2; ex_reg_dst=3 writes register 26
// PORTS
//  clk                   in   1       clock, rising edge
//  rst                   in   1       synchronous reset, active-high
//  ex_valid              in   1       ID/EX holds a real instruction
//  ex_alu_op             in   4       0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 NOR 6 SLT 7 SLTU 8 SLL 9 SRL 10 SRA 11 PASSB
//  ex_alu_sign           in   1       1: ADD/SUB overflow ignored, SLT signed (SLTU always unsigned)
//  ex_src_sel            in   2       [1] op1=ex_shamt, [0] op2=ex_imm
//  ex_reg_dst            in   2       0 rt, 1 rd, 2 LINK_REG, 3 r26
//  ex_md_op              in   3       0 none 1 MULT 2 MULTU 3 DIV 4 DIVU 5 MTHI 6 MTLO
//  ex_res_sel            in   2       0 ALU, 1 HI, 2 LO, 3 ex_pc_plus4
//  ex_shamt, ex_imm      in   XLEN    alternate operands
//  ex_rs, ex_rt, ex_rd   in   RAW     register indices
//  ex_rs_data/ex_rt_data in   XLEN    register-file read data
//  ex_ctrl               in   5       {mem_to_reg[1:0], reg_write, mem_read, mem_write}, passed through
//  ex_pc_plus4           in   XLEN    passed through
//  mem_reg_write/_reg/_data in 1/RAW/XLEN  MEM-stage writeback (forward source, priority)
//  wb_reg_write/_reg/_data  in 1/RAW/XLEN  WB-stage writeback (forward source)
//  ex_flush              in   1       turn this cycle's EX/MEM capture into a bubble
//  ex_stall              out  1       hold PC, IF/ID, ID/EX this cycle
//  md_busy               out  1       mul/div iteration in progress
//  ex_write_register     out  RAW     decoded destination (comb.)
//  ex_result             out  XLEN    selected result (comb., forwarded to ID)
//  em_valid, em_result, em_mem_write_data, em_write_register, em_ctrl, em_pc_plus4
//                        out  1/XLEN/XLEN/RAW/5/XLEN   EX/MEM register
// BEHAVIOUR
//  - Forward per operand: MEM if reg_write & reg!=0 & reg==idx; else WB same test; else RF.
//    em_mem_write_data = forwarded rt value.
//  - Shifts use op1[log2(XLEN)-1:0] as amount on op2; SLT/SLTU result zero-extended 0/1.
//  - Stall: ex_stall = ex_valid & md_busy & (ex_md_op!=0 | ex_res_sel in {1,2}).
//    First stall cycle latches forwarded A/B into hold regs; while stalled the hold regs
//    are used (forward sources keep advancing). Non-MD instructions never stall.
//  - MD FSM IDLE->RUN->IDLE. IDLE & ex_valid & !ex_stall & !ex_flush & md_op 1-4: latch
//    operands, busy next cycle, XLEN cycles of RUN (1 bit/cycle), HI/LO written on last
//    RUN edge, md_busy deasserts next cycle. Start instr itself advances (no reg write).
//  - MULT/MULTU: {HI,LO}=2*XLEN product. DIV/DIVU: LO=quot, HI=rem (rem sign=dividend).
//    Div by 0: LO=all ones, HI=dividend. Signed MIN/-1: LO=MIN, HI=0.
//  - MTHI/MTLO: write HI/LO at end of cycle, no latency, only when not stalled/flushed.
//  - EX/MEM: on each edge, if ex_stall|ex_flush|!ex_valid capture bubble (em_valid=0,
//    em_ctrl=0, data fields don't-care/held); else capture all fields, em_valid=1.
//  - Flush never aborts a running MD op. Stall and flush together: flush wins for EX/MEM.
//  - rst: FSM IDLE, md_busy=0, HI=LO=0, hold regs cleared, all em_* = 0; aborts MD op.
// TESTING
//  - MEM r5=0x11 & WB r5=0x22 both writing, ADD rs=rt=5 -> em_result 0x22; r0 never forwarded.
//  - MULT 0xFFFFFFFF,2 -> md_busy 32 cycles; MFHI issued next cycle stalls, returns HI=0xFFFFFFFF, LO=0xFFFFFFFE.
//  - DIV 0x80000000/0xFFFFFFFF -> LO 0x80000000, HI 0; DIVU 7/0 -> LO 0xFFFFFFFF, HI 7.
//  - MULT busy, ADD/SW stream -> no stall, em_valid=1 each cycle; second MULT stalls until idle.
//  - Stalled DIV with rs forwarded from MEM: after 2 stall cycles operand still correct (hold regs).
//  - rst asserted mid-DIV -> next cycle md_busy=0, HI=LO=0, em_valid=0; ex_flush -> em_ctrl=0.

Source files
------------

// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - execute stage: operand forwarding, ALU, iterative HI/LO mul/div, EX/MEM register
module ex_stage_md #(
  parameter int XLEN     = 32,
  parameter int RAW      = 5,
  parameter int LINK_REG = 31
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [3:0]      ex_alu_op,
  input  logic            ex_alu_sign,
  input  logic [1:0]      ex_src_sel,
  input  logic [1:0]      ex_reg_dst,
  input  logic [2:0]      ex_md_op,
  input  logic [1:0]      ex_res_sel,
  input  logic [XLEN-1:0] ex_shamt,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [RAW-1:0]  ex_rs,
  input  logic [RAW-1:0]  ex_rt,
  input  logic [RAW-1:0]  ex_rd,
  input  logic [XLEN-1:0] ex_rs_data,
  input  logic [XLEN-1:0] ex_rt_data,
  input  logic [4:0]      ex_ctrl,
  input  logic [XLEN-1:0] ex_pc_plus4,
  input  logic            mem_reg_write,
  input  logic [RAW-1:0]  mem_reg,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_reg_write,
  input  logic [RAW-1:0]  wb_reg,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_flush,
  output logic            ex_stall,
  output logic            md_busy,
  output logic [RAW-1:0]  ex_write_register,
  output logic [XLEN-1:0] ex_result,
  output logic            em_valid,
  output logic [XLEN-1:0] em_result,
  output logic [XLEN-1:0] em_mem_write_data,
  output logic [RAW-1:0]  em_write_register,
  output logic [4:0]      em_ctrl,
  output logic [XLEN-1:0] em_pc_plus4
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic {MD_IDLE, MD_RUN} md_state_t;
  md_state_t state, state_n;

  logic [XLEN-1:0]   fwd_a, fwd_b, hold_a, hold_b, opa, opb, op1, op2, alu;
  logic              stall_q;
  logic [XLEN-1:0]   hi, lo;
  logic [2*XLEN-1:0] acc, step_next, prod_fin;
  logic [XLEN-1:0]   mcand, dividend, fin_hi, fin_lo;
  logic [SHW-1:0]    cnt;
  logic              md_div, md_neg_q, md_neg_r, md_div_zero;
  logic              md_start, md_is_div, md_is_signed, a_neg, b_neg;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              mt_ok;

  always_comb begin
    fwd_a = ex_rs_data;
    if (mem_reg_write && mem_reg != '0 && mem_reg == ex_rs) fwd_a = mem_data;
    else if (wb_reg_write && wb_reg != '0 && wb_reg == ex_rs) fwd_a = wb_data;
    fwd_b = ex_rt_data;
    if (mem_reg_write && mem_reg != '0 && mem_reg == ex_rt) fwd_b = mem_data;
    else if (wb_reg_write && wb_reg != '0 && wb_reg == ex_rt) fwd_b = wb_data;
  end

  // Once stalled, the forward sources move on; the held copies stay authoritative
  // until the stalled instruction finally advances.
  assign opa = stall_q ? hold_a : fwd_a;
  assign opb = stall_q ? hold_b : fwd_b;
  assign op1 = ex_src_sel[1] ? ex_shamt : opa;
  assign op2 = ex_src_sel[0] ? ex_imm : opb;

  always_comb begin
    alu = '0;
    case (ex_alu_op)
      4'd0:  alu = op1 + op2;
      4'd1:  alu = op1 - op2;
      4'd2:  alu = op1 & op2;
      4'd3:  alu = op1 | op2;
      4'd4:  alu = op1 ^ op2;
      4'd5:  alu = ~(op1 | op2);
      4'd6:  alu = {{(XLEN-1){1'b0}}, ex_alu_sign ? ($signed(op1) < $signed(op2)) : (op1 < op2)};
      4'd7:  alu = {{(XLEN-1){1'b0}}, op1 < op2};
      4'd8:  alu = op2 << op1[SHW-1:0];
      4'd9:  alu = op2 >> op1[SHW-1:0];
      4'd10: alu = XLEN'($signed(op2) >>> op1[SHW-1:0]);
      4'd11: alu = op2;
      default: alu = '0;
    endcase
  end

  always_comb begin
    ex_write_register = ex_rt;
    case (ex_reg_dst)
      2'd0: ex_write_register = ex_rt;
      2'd1: ex_write_register = ex_rd;
      2'd2: ex_write_register = RAW'(LINK_REG);
      2'd3: ex_write_register = RAW'(26);
      default: ex_write_register = ex_rt;
    endcase
  end

  always_comb begin
    ex_result = alu;
    case (ex_res_sel)
      2'd1: ex_result = hi;
      2'd2: ex_result = lo;
      2'd3: ex_result = ex_pc_plus4;
      default: ex_result = alu;
    endcase
  end

  assign md_busy  = (state == MD_RUN);
  assign ex_stall = ex_valid & md_busy & ((ex_md_op != 3'd0) | (ex_res_sel == 2'd1) | (ex_res_sel == 2'd2));
  assign mt_ok    = ex_valid & ~ex_stall & ~ex_flush;
  assign md_start = (state == MD_IDLE) & mt_ok & (ex_md_op >= 3'd1) & (ex_md_op <= 3'd4);

  assign md_is_div    = (ex_md_op == 3'd3) | (ex_md_op == 3'd4);
  assign md_is_signed = (ex_md_op == 3'd1) | (ex_md_op == 3'd3);
  assign a_neg        = md_is_signed & opa[XLEN-1];
  assign b_neg        = md_is_signed & opb[XLEN-1];

  always_comb begin
    state_n = state;
    case (state)
      MD_IDLE: if (md_start) state_n = MD_RUN;
      MD_RUN:  if (cnt == '0) state_n = MD_IDLE;
      default: state_n = MD_IDLE;
    endcase
  end

  // Unsigned shift-add multiply / restoring divide on magnitudes; signs fixed on the last step.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mcand} : '0);
    div_sh    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_sh - {1'b0, mcand};
    if (md_div)
      step_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                 : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      step_next = {mul_sum, acc[XLEN-1:1]};
    prod_fin = md_neg_q ? -step_next : step_next;
    if (!md_div) begin
      fin_hi = prod_fin[2*XLEN-1:XLEN];
      fin_lo = prod_fin[XLEN-1:0];
    end else if (md_div_zero) begin
      fin_hi = dividend;
      fin_lo = '1;
    end else begin
      fin_hi = md_neg_r ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];
      fin_lo = md_neg_q ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0; mcand <= '0; dividend <= '0; cnt <= '0;
      md_div <= 1'b0; md_neg_q <= 1'b0; md_neg_r <= 1'b0; md_div_zero <= 1'b0;
      hi <= '0; lo <= '0;
      hold_a <= '0; hold_b <= '0; stall_q <= 1'b0;
    end else begin
      stall_q <= ex_stall;
      if (ex_stall && !stall_q) begin
        hold_a <= fwd_a;
        hold_b <= fwd_b;
      end
      if (md_start) begin
        acc         <= {{XLEN{1'b0}}, a_neg ? -opa : opa};
        mcand       <= b_neg ? -opb : opb;
        dividend    <= opa;
        cnt         <= SHW'(XLEN-1);
        md_div      <= md_is_div;
        md_neg_q    <= a_neg ^ b_neg;
        md_neg_r    <= a_neg;
        md_div_zero <= (opb == '0);
      end else if (state == MD_RUN) begin
        acc <= step_next;
        cnt <= cnt - 1'b1;
      end
      if (state == MD_RUN && cnt == '0) begin
        hi <= fin_hi;
        lo <= fin_lo;
      end else if (mt_ok && ex_md_op == 3'd5) begin
        hi <= opa;
      end else if (mt_ok && ex_md_op == 3'd6) begin
        lo <= opa;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      em_valid <= 1'b0; em_result <= '0; em_mem_write_data <= '0;
      em_write_register <= '0; em_ctrl <= '0; em_pc_plus4 <= '0;
    end else if (ex_stall || ex_flush || !ex_valid) begin
      em_valid <= 1'b0;
      em_ctrl  <= '0;
    end else begin
      em_valid          <= 1'b1;
      em_result         <= ex_result;
      em_mem_write_data <= opb;
      em_write_register <= ex_write_register;
      em_ctrl           <= ex_ctrl;
      em_pc_plus4       <= ex_pc_plus4;
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// tb/tb_ex_stage_md.sv - self-checking bench for ex_stage_md (vector table + EX/MEM scoreboard)
module tb_ex_stage_md;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_alu_sign, ex_flush;
  logic [3:0]  ex_alu_op;
  logic [1:0]  ex_src_sel, ex_reg_dst, ex_res_sel;
  logic [2:0]  ex_md_op;
  logic [31:0] ex_shamt, ex_imm, ex_rs_data, ex_rt_data, ex_pc_plus4, mem_data, wb_data;
  logic [4:0]  ex_rs, ex_rt, ex_rd, ex_ctrl, mem_reg, wb_reg;
  logic        mem_reg_write, wb_reg_write;
  logic        ex_stall, md_busy, em_valid;
  logic [4:0]  ex_write_register, em_write_register, em_ctrl;
  logic [31:0] ex_result, em_result, em_mem_write_data, em_pc_plus4;

  ex_stage_md #(.XLEN(32), .RAW(5), .LINK_REG(31)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_sign(ex_alu_sign),
    .ex_src_sel(ex_src_sel), .ex_reg_dst(ex_reg_dst), .ex_md_op(ex_md_op), .ex_res_sel(ex_res_sel),
    .ex_shamt(ex_shamt), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_ctrl(ex_ctrl), .ex_pc_plus4(ex_pc_plus4),
    .mem_reg_write(mem_reg_write), .mem_reg(mem_reg), .mem_data(mem_data),
    .wb_reg_write(wb_reg_write), .wb_reg(wb_reg), .wb_data(wb_data), .ex_flush(ex_flush),
    .ex_stall(ex_stall), .md_busy(md_busy), .ex_write_register(ex_write_register),
    .ex_result(ex_result), .em_valid(em_valid), .em_result(em_result),
    .em_mem_write_data(em_mem_write_data), .em_write_register(em_write_register),
    .em_ctrl(em_ctrl), .em_pc_plus4(em_pc_plus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        valid;
    logic        chk;
    logic [31:0] result;
    logic [31:0] wdata;
    logic [4:0]  wreg;
    logic [4:0]  ctrl;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic        sgn;
    logic [1:0]  src;
    logic [1:0]  dst;
    logic [31:0] a, b, imm, shamt, res;
    logic [4:0]  wreg;
  } vec_t;

  exp_t sbq[$];
  vec_t vt[15];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   busy_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input logic v, input logic c, input logic [31:0] r,
                          input logic [31:0] wd, input logic [4:0] wr, input logic [4:0] ct);
    exp_t e;
    e.name = name; e.valid = v; e.chk = c; e.result = r; e.wdata = wd; e.wreg = wr; e.ctrl = ct;
    sbq.push_back(e);
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL sb_empty: got no expectation expected one");
    end else begin
      e = sbq.pop_front();
      check({e.name, "_valid"}, {31'd0, em_valid}, {31'd0, e.valid});
      check({e.name, "_ctrl"}, {27'd0, em_ctrl}, {27'd0, e.ctrl});
      if (e.valid && e.chk) begin
        check({e.name, "_result"}, em_result, e.result);
        check({e.name, "_wdata"}, em_mem_write_data, e.wdata);
        check({e.name, "_wreg"}, {27'd0, em_write_register}, {27'd0, e.wreg});
      end
    end
  endtask

  task automatic clear_inputs();
    ex_valid = 0; ex_alu_op = 0; ex_alu_sign = 1; ex_src_sel = 0; ex_reg_dst = 0; ex_md_op = 0;
    ex_res_sel = 0; ex_shamt = 0; ex_imm = 0; ex_rs = 1; ex_rt = 2; ex_rd = 3;
    ex_rs_data = 0; ex_rt_data = 0; ex_ctrl = 0; ex_pc_plus4 = 32'h100; ex_flush = 0;
    mem_reg_write = 0; mem_reg = 0; mem_data = 0; wb_reg_write = 0; wb_reg = 0; wb_data = 0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 200 && md_busy; k++) begin
      @(posedge clk);
      #1;
    end
    check({name, "_idle"}, {31'd0, md_busy}, 32'd0);
  endtask

  task automatic read_hilo(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    ex_valid = 1; ex_md_op = 0; ex_res_sel = 1;
    #1 check({name, "_hi"}, ex_result, exp_hi);
    ex_res_sel = 2;
    #1 check({name, "_lo"}, ex_result, exp_lo);
    ex_valid = 0; ex_res_sel = 0;
  endtask

  task automatic issue_md(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    clear_inputs();
    ex_valid = 1; ex_md_op = op; ex_rs_data = a; ex_rt_data = b;
    push_exp(name, 1, 0, 0, 0, 0, 0);
    step();
    ex_valid = 0; ex_md_op = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{4'd0,  1'b1, 2'd0, 2'd1, 32'd5,        32'd7,        32'd0,        32'd0,  32'd12,       5'd3};
    vt[1]  = '{4'd1,  1'b1, 2'd0, 2'd0, 32'd5,        32'd7,        32'd0,        32'd0,  32'hFFFFFFFE, 5'd2};
    vt[2]  = '{4'd2,  1'b1, 2'd0, 2'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'd0,  32'hF000F000, 5'd3};
    vt[3]  = '{4'd3,  1'b1, 2'd0, 2'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'd0,  32'hFFF0FFF0, 5'd3};
    vt[4]  = '{4'd4,  1'b1, 2'd0, 2'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'd0,  32'h0FF00FF0, 5'd3};
    vt[5]  = '{4'd5,  1'b1, 2'd0, 2'd1, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0,        32'd0,  32'h000F000F, 5'd3};
    vt[6]  = '{4'd6,  1'b1, 2'd0, 2'd1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,  32'd1,        5'd3};
    vt[7]  = '{4'd6,  1'b0, 2'd0, 2'd1, 32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,  32'd0,        5'd3};
    vt[8]  = '{4'd7,  1'b1, 2'd0, 2'd1, 32'd1,        32'hFFFFFFFF, 32'd0,        32'd0,  32'd1,        5'd3};
    vt[9]  = '{4'd8,  1'b1, 2'd2, 2'd1, 32'hFFFFFFFF, 32'h000000F1, 32'd0,        32'd4,  32'h00000F10, 5'd3};
    vt[10] = '{4'd9,  1'b1, 2'd2, 2'd2, 32'd0,        32'h80000000, 32'd0,        32'd4,  32'h08000000, 5'd31};
    vt[11] = '{4'd10, 1'b1, 2'd2, 2'd3, 32'd0,        32'h80000000, 32'd0,        32'd4,  32'hF8000000, 5'd26};
    vt[12] = '{4'd11, 1'b1, 2'd1, 2'd1, 32'd0,        32'd0,        32'h12345678, 32'd0,  32'h12345678, 5'd3};
    vt[13] = '{4'd0,  1'b1, 2'd1, 2'd1, 32'h10,       32'd9,        32'hFFFFFFF0, 32'd0,  32'd0,        5'd3};
    vt[14] = '{4'd8,  1'b1, 2'd2, 2'd1, 32'd0,        32'd1,        32'd0,        32'h24, 32'h10,       5'd3};

    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_em_valid", {31'd0, em_valid}, 32'd0);
    check("rst_em_result", em_result, 32'd0);
    check("rst_md_busy", {31'd0, md_busy}, 32'd0);
    read_hilo("rst", 32'd0, 32'd0);

    for (int i = 0; i < 15; i++) begin
      clear_inputs();
      ex_valid = 1; ex_alu_op = vt[i].op; ex_alu_sign = vt[i].sgn; ex_src_sel = vt[i].src;
      ex_reg_dst = vt[i].dst; ex_rs_data = vt[i].a; ex_rt_data = vt[i].b; ex_imm = vt[i].imm;
      ex_shamt = vt[i].shamt; ex_ctrl = 5'b00100;
      push_exp($sformatf("vec%0d", i), 1, 1, vt[i].res, vt[i].b, vt[i].wreg, 5'b00100);
      step();
    end

    // forwarding priority and r0 exclusion
    clear_inputs();
    ex_valid = 1; ex_reg_dst = 1; ex_ctrl = 5'b00100; ex_rs = 5; ex_rt = 5;
    ex_rs_data = 32'h99; ex_rt_data = 32'h99;
    mem_reg_write = 1; mem_reg = 5; mem_data = 32'h11; wb_reg_write = 1; wb_reg = 5; wb_data = 32'h22;
    push_exp("fwd_mem", 1, 1, 32'h22, 32'h11, 5'd3, 5'b00100);
    step();
    mem_reg = 6;
    push_exp("fwd_wb", 1, 1, 32'h44, 32'h22, 5'd3, 5'b00100);
    step();
    mem_reg = 0; wb_reg = 0; ex_rs = 0; ex_rt = 0; ex_rs_data = 3; ex_rt_data = 3;
    push_exp("fwd_r0", 1, 1, 32'd6, 32'd3, 5'd3, 5'b00100);
    step();

    // MULT -1*2, MFHI stalls for the whole iteration
    issue_md("mult_issue", 3'd1, 32'hFFFFFFFF, 32'd2);
    check("mult_busy", {31'd0, md_busy}, 32'd1);
    ex_valid = 1; ex_res_sel = 1; ex_reg_dst = 1; ex_rd = 7; ex_ctrl = 5'b00100;
    #1 check("mfhi_stall", {31'd0, ex_stall}, 32'd1);
    busy_cnt = 0;
    for (int k = 0; k < 100 && md_busy; k++) begin
      busy_cnt++;
      @(posedge clk);
      #1;
    end
    check("mult_busy_cycles", busy_cnt, 32'd32);
    check("stall_bubble", {31'd0, em_valid}, 32'd0);
    check("mfhi_released", {31'd0, ex_stall}, 32'd0);
    push_exp("mfhi", 1, 1, 32'hFFFFFFFF, 32'd2, 5'd7, 5'b00100);
    step();
    ex_res_sel = 2;
    push_exp("mflo", 1, 1, 32'hFFFFFFFE, 32'd2, 5'd7, 5'b00100);
    step();

    // division corner cases
    issue_md("div_min", 3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div_min");
    read_hilo("div_min", 32'd0, 32'h80000000);
    issue_md("divu_zero", 3'd4, 32'd7, 32'd0);
    wait_idle("divu_zero");
    read_hilo("divu_zero", 32'd7, 32'hFFFFFFFF);
    issue_md("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2);
    wait_idle("div_neg");
    read_hilo("div_neg", 32'hFFFFFFFF, 32'hFFFFFFFD);

    // MTHI / MTLO take effect immediately
    issue_md("mthi", 3'd5, 32'hABCD, 32'd0);
    issue_md("mtlo", 3'd6, 32'h1234, 32'd0);
    read_hilo("mt", 32'hABCD, 32'h1234);

    // non-MD instructions stream past a busy unit; a second MULT waits
    issue_md("mult2", 3'd1, 32'd3, 32'd5);
    for (int k = 0; k < 5; k++) begin
      clear_inputs();
      ex_valid = 1; ex_reg_dst = 1; ex_ctrl = 5'b00101; ex_rs_data = k; ex_rt_data = 32'd100;
      #1 check($sformatf("stream%0d_stall", k), {31'd0, ex_stall}, 32'd0);
      push_exp($sformatf("stream%0d", k), 1, 1, 32'd100 + k, 32'd100, 5'd3, 5'b00101);
      step();
    end
    clear_inputs();
    ex_valid = 1; ex_md_op = 1; ex_rs_data = 32'h10; ex_rt_data = 32'h10;
    #1 check("mult3_stall", {31'd0, ex_stall}, 32'd1);
    wait_idle("mult2");
    push_exp("mult3_start", 1, 0, 0, 0, 0, 0);
    step();
    check("mult3_busy", {31'd0, md_busy}, 32'd1);
    ex_valid = 0; ex_md_op = 0;
    wait_idle("mult3");
    read_hilo("mult3", 32'd0, 32'h100);

    // stalled DIVU keeps its forwarded operands after the sources move on
    issue_md("mult4", 3'd2, 32'd1, 32'd1);
    ex_valid = 1; ex_md_op = 4; ex_rs = 8; ex_rt = 9; ex_rs_data = 32'd55; ex_rt_data = 32'd7;
    mem_reg_write = 1; mem_reg = 8; mem_data = 32'd100;
    #1 check("hold_stall", {31'd0, ex_stall}, 32'd1);
    @(posedge clk);
    #1 mem_reg_write = 0; mem_data = 32'd999; ex_rt_data = 32'd3;
    repeat (2) @(posedge clk);
    #1 check("hold_still_stalled", {31'd0, ex_stall}, 32'd1);
    wait_idle("mult4");
    push_exp("hold_divu_start", 1, 0, 0, 0, 0, 0);
    step();
    ex_valid = 0; ex_md_op = 0;
    wait_idle("hold_divu");
    read_hilo("hold_divu", 32'd2, 32'd14);

    // reset during a running divide
    issue_md("rst_divu", 3'd4, 32'd100, 32'd7);
    ex_valid = 1; ex_ctrl = 5'b00100;
    repeat (5) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    check("rst_mid_busy", {31'd0, md_busy}, 32'd0);
    check("rst_mid_em_valid", {31'd0, em_valid}, 32'd0);
    check("rst_mid_em_result", em_result, 32'd0);
    read_hilo("rst_mid", 32'd0, 32'd0);

    // flush turns the capture into a bubble
    clear_inputs();
    ex_valid = 1; ex_ctrl = 5'b11111; ex_reg_dst = 1; ex_rs_data = 1; ex_rt_data = 2; ex_flush = 1;
    push_exp("flush", 0, 0, 0, 0, 0, 5'b00000);
    step();
    ex_flush = 0;
    push_exp("after_flush", 1, 1, 32'd3, 32'd2, 5'd3, 5'b11111);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
